// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fsm_e       : fetch FSM states (IDLE, REQ, WAIT)
//   NOP_INSTR   : word returned on any error / non-valid case (addi x0,x0,0)
//   *_DEF       : default widths and timeout
//   ofs_w/cnt_w : derived widths (byte-offset bits, timeout counter bits)
package ifetch_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 255;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Byte-offset bits of one instruction word; non-zero offset means misaligned.
  localparam int BYTE_OFS_W = $clog2(DATA_W_DEF / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fsm_e;

  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read bus (req/gnt/rvalid).
//   master : fetch unit  -> drives mem_req/mem_addr, receives gnt/rvalid/rdata/err
//   slave  : memory side -> the mirror image
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/fetch_line_buf.sv
// Single-entry instruction line buffer.
//   wr_en_i/wr_addr_i/wr_data_i/wr_err_i : fill port (sets valid)
//   inv_i                                : invalidate; wins over a same-cycle write
//   cmp_addr_i -> match_o                : combinational valid & address compare
//   data_o/err_o                         : stored word and its error flag
module fetch_line_buf
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_err_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic              match_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      addr_q  <= wr_addr_i;
      data_q  <= wr_data_i;
      err_q   <= wr_err_i;
    end
  end

  assign match_o = valid_q && (addr_q == cmp_addr_i);
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: returns the word for `pc` from a one-entry line
// buffer in the same cycle, otherwise stalls the core and fills the buffer
// over a req/gnt/rvalid bus with variable latency.
//   clk, rst_n            : clock, async active-low reset
//   pc, flush             : fetch address; invalidate + drop in-flight response
//   instr, instr_valid    : instruction for pc (NOP when not valid or error)
//   fetch_err             : misaligned pc, bus error or timeout (with instr_valid)
//   stall                 : core must hold pc and not commit
//   mem (ifetch_if.master): instruction memory read bus
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                MAX_WAIT = MAX_WAIT_DEF,
  parameter logic [DATA_W-1:0] NOP      = DATA_W'(NOP_INSTR)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic              stall,
  ifetch_if.master          mem
);

  localparam int              OFS_W    = ofs_w(DATA_W);
  localparam int              CNT_W    = cnt_w(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  fsm_e              state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // doubles as req_addr for the fill
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;

  logic              buf_match, buf_err, buf_wr, buf_wr_err;
  logic [DATA_W-1:0] buf_data;
  logic              misal, hit, miss;

  fetch_line_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (buf_wr),
    .wr_addr_i  (addr_q),
    .wr_data_i  (mem.mem_rdata),
    .wr_err_i   (buf_wr_err),
    .inv_i      (flush),
    .cmp_addr_i (pc),
    .match_o    (buf_match),
    .data_o     (buf_data),
    .err_o      (buf_err)
  );

  assign misal = |pc[OFS_W-1:0];
  assign hit   = buf_match & ~flush;
  assign miss  = rst_n & ~misal & ~hit;

  // Core-side outputs. Gated by rst_n so reset forces them quiet even
  // though they are combinational.
  always_comb begin
    instr       = NOP;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    stall       = 1'b0;
    if (rst_n) begin
      if (misal) begin
        instr_valid = 1'b1;
        fetch_err   = 1'b1;
      end else if (hit) begin
        instr_valid = 1'b1;
        fetch_err   = buf_err;
        instr       = buf_err ? NOP : buf_data;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    buf_wr     = 1'b0;
    buf_wr_err = 1'b0;
    case (state_q)
      IDLE: if (miss && !flush) begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc;
      end
      REQ: if (mem.mem_gnt) begin
        state_d = WAIT;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          state_d    = IDLE;
          drop_d     = 1'b0;
          buf_wr     = ~drop_q & ~flush;
          buf_wr_err = mem.mem_err;
        end else if (cnt_q == LAST_CNT) begin
          // Timeout: park an error entry so the core sees fetch_err.
          state_d    = IDLE;
          drop_d     = 1'b0;
          buf_wr     = ~drop_q & ~flush;
          buf_wr_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Only mark a drop while a response is still owed; a response arriving
    // together with flush is already consumed above.
    if (flush && state_d != IDLE) drop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          MW   = 4;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc = '0;
  logic          flush = 1'b1;
  logic [31:0]   instr;
  logic          instr_valid, fetch_err, stall;

  ifetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .NOP(NOPW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .stall       (stall),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  int passed = 0, fails = 0, total = 0;

  // memory responder state
  int          gnt_lat = 0, rlat = 0, gnt_cnt = 0, resp_cnt = 0, grants = 0;
  bit          resp_pend = 0, respond = 1, err_mode = 0, force_rv = 0, rand_lat = 0;
  logic [31:0] resp_addr = '0;
  logic [7:0]  salt = 8'd0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;

  // Instruction memory contents; salt lets a re-fetch return a different word.
  function automatic logic [31:0] memword(input logic [31:0] a, input logic [7:0] s);
    if (a == 32'h100) return 32'h0050_0093;
    return {s, a[21:2], 4'h3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mem_drive();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
    bus.mem_rdata  = $urandom;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = memword(resp_addr, salt);
        bus.mem_err    = err_mode;
        resp_pend      = 0;
      end else resp_cnt--;
    end
    if (force_rv) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hdead_beef;
      force_rv       = 0;
    end
    if (bus.mem_req) begin
      if (gnt_cnt == 0) begin
        bus.mem_gnt = 1'b1;
        grants++;
        resp_addr = bus.mem_addr;
        if (respond) begin
          resp_pend = 1;
          resp_cnt  = rlat;
        end
        gnt_cnt = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
        if (rand_lat) rlat = $urandom_range(0, 3);
      end else gnt_cnt--;
    end
  endtask

  // One clock cycle: new inputs just after the edge, outputs settled 2 units later.
  task automatic cycle(input logic [31:0] p, input logic f);
    @(posedge clk);
    #1;
    pc    = p;
    flush = f;
    if (prev_hold && rst_n) begin
      chk("req_hold", {31'b0, bus.mem_req}, 32'd1);
      chk("addr_hold", bus.mem_addr, prev_addr);
    end
    mem_drive();
    #1;
    prev_hold = bus.mem_req & ~bus.mem_gnt;
    prev_addr = bus.mem_addr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          g0, n;
    bit          got;
    logic [31:0] p;
    int          k;

    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    #2;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_instr", instr, NOPW);
    chk("rst_ferr",  {31'b0, fetch_err}, 32'd0);
    chk("rst_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;   // flush still high: nothing starts before the first step

    // cold miss, minimum latency
    cycle(32'h100, 0);
    chk("cm_T_stall", {31'b0, stall}, 32'd1);
    chk("cm_T_valid", {31'b0, instr_valid}, 32'd0);
    chk("cm_T_req",   {31'b0, bus.mem_req}, 32'd0);
    cycle(32'h100, 0);
    chk("cm_T1_req",   {31'b0, bus.mem_req}, 32'd1);
    chk("cm_T1_addr",  bus.mem_addr, 32'h100);
    chk("cm_T1_stall", {31'b0, stall}, 32'd1);
    cycle(32'h100, 0);
    chk("cm_T2_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("cm_T2_stall", {31'b0, stall}, 32'd1);
    cycle(32'h100, 0);
    chk("cm_T3_valid", {31'b0, instr_valid}, 32'd1);
    chk("cm_T3_instr", instr, 32'h0050_0093);
    chk("cm_T3_stall", {31'b0, stall}, 32'd0);
    chk("cm_T3_ferr",  {31'b0, fetch_err}, 32'd0);

    // re-hit
    g0 = grants;
    repeat (4) begin
      cycle(32'h100, 0);
      chk("rh_valid", {31'b0, instr_valid}, 32'd1);
      chk("rh_stall", {31'b0, stall}, 32'd0);
      chk("rh_req",   {31'b0, bus.mem_req}, 32'd0);
    end
    chk("rh_grants", grants - g0, 32'd0);

    // flush while in WAIT; first response discarded
    rlat = 2;
    g0   = grants;
    cycle(32'h200, 0);
    cycle(32'h200, 0);
    cycle(32'h200, 1);
    chk("fl_stall", {31'b0, stall}, 32'd1);
    cycle(32'h100, 0);
    chk("fl_inv", {31'b0, stall}, 32'd1);
    cycle(32'h200, 0);
    salt = 8'd1;
    cycle(32'h200, 0);
    chk("fl_discard", {31'b0, instr_valid}, 32'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(32'h200, 0);
      if (instr_valid) begin got = 1; break; end
    end
    chk("fl_got",    {31'b0, got}, 32'd1);
    chk("fl_instr",  instr, memword(32'h200, 8'd1));
    chk("fl_grants", grants - g0, 32'd2);
    rlat = 0;

    // bus error
    err_mode = 1;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(32'h300, 0);
      if (instr_valid) begin n = i; break; end
    end
    chk("be_lat",   n, 32'd3);
    chk("be_ferr",  {31'b0, fetch_err}, 32'd1);
    chk("be_instr", instr, NOPW);
    chk("be_stall", {31'b0, stall}, 32'd0);
    err_mode = 0;

    // timeout: granted, never answered
    respond = 0;
    cycle(32'h400, 0);
    cycle(32'h400, 0);
    chk("to_req", {31'b0, bus.mem_req}, 32'd1);
    repeat (4) cycle(32'h400, 0);
    chk("to_early", {31'b0, instr_valid}, 32'd0);
    cycle(32'h400, 0);
    chk("to_valid", {31'b0, instr_valid}, 32'd1);
    chk("to_ferr",  {31'b0, fetch_err}, 32'd1);
    chk("to_instr", instr, NOPW);
    force_rv = 1;
    cycle(32'h400, 0);
    cycle(32'h400, 0);
    chk("late_ferr",  {31'b0, fetch_err}, 32'd1);
    chk("late_instr", instr, NOPW);
    chk("late_req",   {31'b0, bus.mem_req}, 32'd0);

    // async reset in WAIT, then misaligned pc
    cycle(32'h500, 0);
    cycle(32'h500, 0);
    cycle(32'h500, 0);
    chk("rw_stall_pre", {31'b0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_stall", {31'b0, stall}, 32'd0);
    resp_pend = 0; gnt_cnt = 0; prev_hold = 0;
    @(posedge clk);
    #1;
    flush = 1'b1; pc = 32'h102; rst_n = 1'b1;
    cycle(32'h102, 0);
    chk("ma_ferr",  {31'b0, fetch_err}, 32'd1);
    chk("ma_valid", {31'b0, instr_valid}, 32'd1);
    chk("ma_instr", instr, NOPW);
    chk("ma_stall", {31'b0, stall}, 32'd0);
    cycle(32'h102, 0);
    chk("ma_req", {31'b0, bus.mem_req}, 32'd0);
    respond = 1;
    cycle(32'h100, 0);
    chk("rst_buf_clear", {31'b0, stall}, 32'd1);

    // randomized: every delivered word must match memory for the held pc
    rand_lat = 1;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 4);
      if (k == 4) p = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
      else        p = 32'h1000 + 32'(4 * k);
      got = 0;
      for (int c = 0; c < 40; c++) begin
        cycle(p, (c == 0) && ($urandom_range(0, 7) == 0));
        chk("rnd_stall", {31'b0, stall}, {31'b0, !instr_valid});
        if (instr_valid) begin got = 1; break; end
      end
      chk("rnd_got", {31'b0, got}, 32'd1);
      if (p[1:0] != 2'b00) begin
        chk("rnd_ma_ferr",  {31'b0, fetch_err}, 32'd1);
        chk("rnd_ma_instr", instr, NOPW);
      end else begin
        chk("rnd_ferr",  {31'b0, fetch_err}, 32'd0);
        chk("rnd_instr", instr, memword(p, salt));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
